trace_pkt_sender: RTL and testbench
===================================

Name: trace_pkt_sender

Overview:
Parametrised successor to the trace packet splitter. Pulls fixed-length packets of 16-bit words from the trace interface and buffers them in a word FIFO. Serialises them low-byte-first to a byte consumer (UART or other) through a valid/next handshake. Adds whole-packet admission, a saturating drop counter with clear, and an optional TPIU sync-marker insert.

Parameters:
WORDS_PER_PACKET, 8, 16-bit words per trace packet (TPIU frame = 8).
FIFO_WORDS_LOG2, 5, log2 of FIFO depth in words; 2**FIFO_WORDS_LOG2 >= WORDS_PER_PACKET required (elaboration error otherwise).
OVF_CNT_W, 8, width of the dropped-packet counter.

Ports:
clk  in  1  system clock (48 MHz).
rst  in  1  synchronous active-low reset (one clock; synchronous, active-low).
sync  in  1  trace interface in sync.
pkt_avail  in  1  upstream has a complete packet.
pkt_next  out  1  one-cycle strobe: claim next packet.
pkt_next_wd  out  1  one-cycle strobe: advance to next word of claimed packet.
pkt_in  in  16  current packet word.
data_avail  out  1  byte available.
data_val  out  8  current byte, valid while data_avail.
data_next  in  1  consumer takes data_val.
data_ovf  out  1  sticky: at least one packet dropped.
ovf_count  out  OVF_CNT_W  dropped packets, saturating.
ovf_clr  in  1  clears data_ovf and ovf_count.

Behaviour:
- Reset (rst=0 at a clk edge): FSM to IDLE; FIFO emptied; byte pointer to low byte. All outputs 0 from the next cycle. Any partially read packet is abandoned.
- FSM states:
  - IDLE: if sync & pkt_avail, assert pkt_next for one cycle. Go to FETCH when free words >= WORDS_PER_PACKET, otherwise go to DROP. Free words are evaluated in that cycle and include any pop in the same cycle.
  - FETCH: word k (k=0..N-1) is valid on pkt_in k+1 cycles after pkt_next. Write it to the FIFO. Assert pkt_next_wd in the same cycle for every k < N-1. After word N-1, return to IDLE (no pkt_next_wd).
  - DROP: same strobe timing as FETCH, but the words are discarded. On entry, set data_ovf and increment ovf_count, saturating at all-ones.
- Fetch/drop throughput: N+1 cycles per packet; IDLE lasts at least 1 cycle between packets.
- Sync handling:
  - If sync falls mid-FETCH/DROP, the packet completes (upstream already committed).
  - No new packet is claimed while sync=0; nothing is counted as dropped.
- Output side:
  - data_avail = FIFO not empty (registered count).
  - data_val = low byte of head word when pointer=0, high byte when pointer=1.
  - data_avail & data_next: toggle pointer; on a high-byte accept, pop the word.
  - data_next while !data_avail: ignored.
  - Latency: first word written at cycle T; data_avail=1 at T+1.
- Simultaneous events:
  - Pop and push in the same cycle are both honoured; count unchanged.
  - ovf_clr together with a drop entry gives ovf_count=1, data_ovf=1 (the drop wins after the clear).
- FIFO never overflows: admission is whole-packet only. Full is therefore never reached mid-packet.
- Pointer wrap: read/write pointers are FIFO_WORDS_LOG2 bits and wrap naturally. Count is FIFO_WORDS_LOG2+1 bits.

Optional Feature:
Macro TRACE_PKT_SYNC_MARKER_EN.
- Defined:
  - A 0->1 transition of sync sets marker_pending.
  - In IDLE with marker_pending, packet claims are blocked. Once free words >= 2, words 16'hFFFF then 16'h7FFF are written on two consecutive cycles and marker_pending is cleared.
  - The output byte stream then shows FF FF FF 7F.
  - A sync rise during FETCH/DROP is latched and serviced on return to IDLE.
  - Reset clears marker_pending.
- Undefined: no marker logic; sync edges have no effect beyond gating claims.

Decomposition:
- Package trace_pkt_pkg:
  - WORD_W=16, BYTE_W=8.
  - TPIU_SYNC_W0=16'hFFFF, TPIU_SYNC_W1=16'h7FFF.
  - FSM state typedef (IDLE, FETCH, DROP, MARKER).
- One sub-module: sync_word_fifo. Single-clock, parametrised width/depth, push/pop, registered count, free-words output, same-cycle push+pop.

Test Plan:
- Reset, then sync=1 and one packet of words 16'h0201, 16'h0403 ... 16'h100F, with data_next=1 -> bytes 01..10 in order; pkt_next once, pkt_next_wd 7 times; data_avail low after 16 accepts.
- data_next=0; offer 5 packets with default parameters -> 4 stored, 5th claimed and dropped. Expect ovf_count=1, data_ovf=1; then drain 64 bytes, all from packets 1-4.
- sync=0, pkt_avail=1 for 100 cycles -> pkt_next never asserted; ovf_count stays 0.
- OVF_CNT_W=2 with 5 forced drops -> ovf_count=3. Then ovf_clr in the cycle of a 6th drop entry -> ovf_count=1, data_ovf=1.
- Assert rst=0 after word 3 of a fetch -> next cycle all outputs 0, data_avail=0. After release, the next packet is fetched cleanly.
- With TRACE_PKT_SYNC_MARKER_EN, sync 0->1 then one packet -> bytes FF FF FF 7F followed by the 16 packet bytes. Without the macro -> only the 16 packet bytes.

Source files
------------

// File: rtl/trace_pkt_pkg.sv
// Shared types and constants for the trace packet sender.
//   WORD_W / BYTE_W        : trace word and output byte widths
//   TPIU_SYNC_W0 / _W1     : the two words of a TPIU sync marker
//   state_t                : sender FSM state encoding
package trace_pkt_pkg;

   localparam int WORD_W = 16;
   localparam int BYTE_W = 8;

   localparam logic [WORD_W-1:0] TPIU_SYNC_W0 = 16'hFFFF;
   localparam logic [WORD_W-1:0] TPIU_SYNC_W1 = 16'h7FFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DROP   = 2'd2,
      MARKER = 2'd3
   } state_t;

endpackage

// File: rtl/trace_pkt_sender_fifo.sv
// sync_word_fifo: single-clock word FIFO with registered occupancy.
//   clk, rst (sync active-low)
//   push, push_data : write one word
//   pop             : remove head word (ignored when empty)
//   head            : word at the read pointer
//   free_words      : 2**DEPTH_LOG2 - count
//   empty           : count == 0
// Pointers are DEPTH_LOG2 bits and wrap naturally; count is one bit wider.
// Push and pop in the same cycle leave the count unchanged.
module sync_word_fifo #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [DEPTH_LOG2:0]   free_words,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2+1)'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  pop_ok;
   logic                  push_ok;

   assign empty      = (count == '0);
   assign pop_ok     = pop & ~empty;
   // A push into a full FIFO is only taken if a word leaves in the same cycle.
   assign push_ok    = push & ((count != DEPTH_V) | pop_ok);
   assign free_words = DEPTH_V - count;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/trace_pkt_sender.sv
// trace_pkt_sender: claims fixed-length packets of 16-bit trace words,
// buffers them in a word FIFO and serialises them low byte first.
//   clk, rst (sync active-low)
//   sync, pkt_avail, pkt_in     : trace interface inputs
//   pkt_next, pkt_next_wd       : claim-packet / next-word strobes
//   data_avail, data_val        : byte output, data_next accepts it
//   data_ovf, ovf_count, ovf_clr: dropped-packet flag/counter and clear
// Build option: define TRACE_PKT_SYNC_MARKER_EN to insert a TPIU sync
// marker (FFFF, 7FFF) into the stream after each rising edge of sync.
//
// state  | meaning
// IDLE   | waiting; claims a packet (or inserts a marker) when allowed
// FETCH  | receiving words of an admitted packet into the FIFO
// DROP   | receiving words of a packet that did not fit; discarded
// MARKER | writing the second sync-marker word
module trace_pkt_sender
   import trace_pkt_pkg::*;
#(
   parameter int WORDS_PER_PACKET = 8,
   parameter int FIFO_WORDS_LOG2  = 5,
   parameter int OVF_CNT_W        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync,
   input  logic                 pkt_avail,
   output logic                 pkt_next,
   output logic                 pkt_next_wd,
   input  logic [WORD_W-1:0]    pkt_in,
   output logic                 data_avail,
   output logic [BYTE_W-1:0]    data_val,
   input  logic                 data_next,
   output logic                 data_ovf,
   output logic [OVF_CNT_W-1:0] ovf_count,
   input  logic                 ovf_clr
);

   if (2 ** FIFO_WORDS_LOG2 < WORDS_PER_PACKET) begin : g_depth_check
      $error("trace_pkt_sender: FIFO must hold at least one whole packet");
   end

   localparam int CNT_W = FIFO_WORDS_LOG2 + 1;
   localparam int WC_W  = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;

   state_t              state;
   state_t              state_nxt;
   logic [WC_W-1:0]     wd_left;
   logic                byte_hi;
   logic                accept;
   logic                drop_entry;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_empty;
   logic [WORD_W-1:0]   fifo_wdata;
   logic [WORD_W-1:0]   fifo_head;
   logic [CNT_W-1:0]    fifo_free;
   logic [CNT_W:0]      free_eff;
   logic                room_pkt;

`ifdef TRACE_PKT_SYNC_MARKER_EN
   logic sync_q;
   logic marker_pending;
   logic marker_req;
   logic marker_done;
   logic room_marker;
`endif

   sync_word_fifo #(
      .WIDTH      (WORD_W),
      .DEPTH_LOG2 (FIFO_WORDS_LOG2)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fifo_push),
      .push_data  (fifo_wdata),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .free_words (fifo_free),
      .empty      (fifo_empty)
   );

   assign data_avail = ~fifo_empty;
   assign accept     = data_avail & data_next;
   assign fifo_pop   = accept & byte_hi;
   // Gated so the byte output reads zero while the FIFO is empty.
   assign data_val   = !data_avail ? '0 :
                       byte_hi     ? fifo_head[WORD_W-1:BYTE_W] :
                                     fifo_head[BYTE_W-1:0];

   // Admission counts a word leaving in this same cycle as free space.
   assign free_eff = {1'b0, fifo_free} + {{CNT_W{1'b0}}, fifo_pop};
   assign room_pkt = (free_eff >= (CNT_W+1)'(WORDS_PER_PACKET));

`ifdef TRACE_PKT_SYNC_MARKER_EN
   // The rise itself blocks a claim in the same cycle, so the marker
   // always precedes the first packet after sync goes high.
   assign marker_req  = marker_pending | (sync & ~sync_q);
   assign room_marker = (free_eff >= (CNT_W+1)'(2));
`endif

   always_comb begin
      state_nxt   = state;
      pkt_next    = 1'b0;
      pkt_next_wd = 1'b0;
      fifo_push   = 1'b0;
      fifo_wdata  = pkt_in;
      drop_entry  = 1'b0;
`ifdef TRACE_PKT_SYNC_MARKER_EN
      marker_done = 1'b0;
`endif
      case (state)
         IDLE: begin
`ifdef TRACE_PKT_SYNC_MARKER_EN
            if (marker_req) begin
               if (room_marker) begin
                  fifo_push  = 1'b1;
                  fifo_wdata = TPIU_SYNC_W0;
                  state_nxt  = MARKER;
               end
            end else
`endif
            if (sync && pkt_avail) begin
               pkt_next = 1'b1;
               if (room_pkt) begin
                  state_nxt = FETCH;
               end else begin
                  state_nxt  = DROP;
                  drop_entry = 1'b1;
               end
            end
         end
         FETCH: begin
            fifo_push = 1'b1;
            if (wd_left == '0) begin
               state_nxt = IDLE;
            end else begin
               pkt_next_wd = 1'b1;
            end
         end
         DROP: begin
            if (wd_left == '0) begin
               state_nxt = IDLE;
            end else begin
               pkt_next_wd = 1'b1;
            end
         end
         MARKER: begin
`ifdef TRACE_PKT_SYNC_MARKER_EN
            fifo_push   = 1'b1;
            fifo_wdata  = TPIU_SYNC_W1;
            marker_done = 1'b1;
`endif
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         wd_left   <= '0;
         byte_hi   <= 1'b0;
         data_ovf  <= 1'b0;
         ovf_count <= '0;
      end else begin
         state <= state_nxt;

         // Words remaining after the current one; zero marks the last word.
         if (pkt_next) begin
            wd_left <= WC_W'(WORDS_PER_PACKET - 1);
         end else if ((state == FETCH || state == DROP) && wd_left != '0) begin
            wd_left <= wd_left - 1'b1;
         end

         if (accept) begin
            byte_hi <= ~byte_hi;
         end

         // A drop in the same cycle as a clear leaves a count of one.
         if (drop_entry) begin
            data_ovf <= 1'b1;
            if (ovf_clr) begin
               ovf_count <= OVF_CNT_W'(1);
            end else if (ovf_count != '1) begin
               ovf_count <= ovf_count + 1'b1;
            end
         end else if (ovf_clr) begin
            data_ovf  <= 1'b0;
            ovf_count <= '0;
         end
      end
   end

`ifdef TRACE_PKT_SYNC_MARKER_EN
   // Reset samples sync so a level already high is not seen as a new rise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q         <= sync;
         marker_pending <= 1'b0;
      end else begin
         sync_q         <= sync;
         marker_pending <= (sync & ~sync_q) | (marker_pending & ~marker_done);
      end
   end
`endif

endmodule

// File: tb/tb_trace_pkt_sender.sv
module tb_trace_pkt_sender;

   localparam int N     = 8;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sync = 1'b0;
   logic        data_next = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        up_en = 1'b0;
   logic        pkt_avail;
   logic [15:0] pkt_in = 16'h0;

   logic       pkt_next_a, pkt_next_wd_a, data_avail_a, data_ovf_a;
   logic [7:0] data_val_a, ovf_count_a;
   logic       pkt_next_b, pkt_next_wd_b, data_avail_b, data_ovf_b;
   logic [7:0] data_val_b;
   logic [1:0] ovf_count_b;

   // upstream trace source: words offered by the stimulus, consumed on strobes
   logic [15:0] offer_mem [512];
   int          offer_wr = 0;
   int          offer_rd = 0;
   int          up_base = 0;
   int          up_idx = 0;
   bit          up_busy = 1'b0;
   logic        s_pn, s_wd, s_rst;

   assign pkt_avail = up_en & rst & ((offer_wr - offer_rd) >= N);

   always #5 clk = ~clk;

   trace_pkt_sender dut_a (
      .clk(clk), .rst(rst), .sync(sync), .pkt_avail(pkt_avail),
      .pkt_next(pkt_next_a), .pkt_next_wd(pkt_next_wd_a), .pkt_in(pkt_in),
      .data_avail(data_avail_a), .data_val(data_val_a), .data_next(data_next),
      .data_ovf(data_ovf_a), .ovf_count(ovf_count_a), .ovf_clr(ovf_clr)
   );

   trace_pkt_sender #(.OVF_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .sync(sync), .pkt_avail(pkt_avail),
      .pkt_next(pkt_next_b), .pkt_next_wd(pkt_next_wd_b), .pkt_in(pkt_in),
      .data_avail(data_avail_b), .data_val(data_val_b), .data_next(data_next),
      .data_ovf(data_ovf_b), .ovf_count(ovf_count_b), .ovf_clr(ovf_clr)
   );

   always begin
      @(negedge clk);
      #4;
      s_pn  = pkt_next_a;
      s_wd  = pkt_next_wd_a;
      s_rst = rst;
      @(posedge clk);
      #1;
      if (!s_rst) begin
         up_busy = 1'b0;
      end else if (s_pn) begin
         up_base  = offer_rd;
         offer_rd = offer_rd + N;
         up_idx   = 0;
         up_busy  = 1'b1;
      end else if (s_wd && up_idx < N - 1) begin
         up_idx = up_idx + 1;
      end
      pkt_in = up_busy ? offer_mem[up_base + up_idx] : 16'h0;
   end

   // reference model state
   logic [7:0] exp_q [$];
   int occ = 0;
   int exp_ovf8 = 0;
   int exp_ovf2 = 0;
   int n_cmp = 0;
   int n_err = 0;
   int n_pn = 0;
   int n_wd = 0;
   int dn_ctl = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive data_next, sample the current cycle, return at next negedge.
   task automatic step();
      logic [7:0] e;
      data_next = (dn_ctl == 2) ? 1'($urandom_range(0, 1)) : (dn_ctl == 1);
      #1;
      if (pkt_next_a === 1'b1) n_pn++;
      if (pkt_next_wd_a === 1'b1) n_wd++;
      if (data_avail_a === 1'b1 && data_next) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_byte", {24'h0, data_val_a}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("byte", {24'h0, data_val_a}, {24'h0, e});
            chk("byte_b", {24'h0, data_val_b}, {24'h0, e});
         end
      end
      @(negedge clk);
   endtask

   task automatic offer_pkt(input bit fixed, input bit model);
      logic [15:0] w;
      bit keep;
      keep = model && (DEPTH - occ >= N);
      for (int k = 0; k < N; k++) begin
         w = fixed ? {8'(2 * k + 2), 8'(2 * k + 1)} : 16'($urandom);
         offer_mem[offer_wr + k] = w;
         if (keep) begin
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
         end
      end
      offer_wr = offer_wr + N;
      if (model) begin
         if (keep) begin
            occ = occ + N;
         end else begin
            exp_ovf8 = (exp_ovf8 < 255) ? exp_ovf8 + 1 : 255;
            exp_ovf2 = (exp_ovf2 < 3) ? exp_ovf2 + 1 : 3;
         end
      end
   endtask

   task automatic set_sync(input logic v);
`ifdef TRACE_PKT_SYNC_MARKER_EN
      if (v && !sync) begin
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'h7F);
         occ = occ + 2;
      end
`endif
      sync = v;
   endtask

   task automatic wait_claim(input string tag);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (pkt_next_a === 1'b1) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chk(tag, 32'(got), 32'd1);
   endtask

   task automatic settle();
      for (int i = 0; i < 600; i++) begin
         if (offer_rd == offer_wr) break;
         step();
      end
      chk("upstream_consumed", offer_rd, offer_wr);
      repeat (N + 3) step();
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         if (exp_q.size() == 0 && offer_rd == offer_wr) break;
         step();
      end
      repeat (N + 4) step();
      chk("drained", exp_q.size(), 0);
      chk("avail_low_after_drain", {31'h0, data_avail_a}, 32'd0);
      occ = 0;
   endtask

   task automatic chk_ovf(input string tag, input logic flag);
      chk({tag, "_cnt8"}, {24'h0, ovf_count_a}, exp_ovf8);
      chk({tag, "_cnt2"}, {30'h0, ovf_count_b}, exp_ovf2);
      chk({tag, "_flag"}, {31'h0, data_ovf_a}, {31'h0, flag});
      chk({tag, "_flag_b"}, {31'h0, data_ovf_b}, {31'h0, flag});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pkt_next"}, {31'h0, pkt_next_a}, 0);
      chk({tag, "_pkt_next_wd"}, {31'h0, pkt_next_wd_a}, 0);
      chk({tag, "_data_avail"}, {31'h0, data_avail_a}, 0);
      chk({tag, "_data_val"}, {24'h0, data_val_a}, 0);
      chk({tag, "_data_ovf"}, {31'h0, data_ovf_a}, 0);
      chk({tag, "_ovf_count"}, {24'h0, ovf_count_a}, 0);
      chk({tag, "_pkt_next_b"}, {31'h0, pkt_next_b}, 0);
      chk({tag, "_pkt_next_wd_b"}, {31'h0, pkt_next_wd_b}, 0);
      chk({tag, "_data_avail_b"}, {31'h0, data_avail_b}, 0);
      chk({tag, "_ovf_count_b"}, {30'h0, ovf_count_b}, 0);
   endtask

   initial begin
      // reset
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b1;
      step();

      // one fixed packet, consumer always ready
      n_pn = 0;
      n_wd = 0;
      up_en = 1'b1;
      set_sync(1'b1);
      dn_ctl = 1;
      offer_pkt(1'b1, 1'b1);
      drain(300);
      chk("t1_pkt_next_count", n_pn, 1);
      chk("t1_pkt_next_wd_count", n_wd, N - 1);

      // five random packets with consumer stalled: four fit, one dropped
      dn_ctl = 0;
      n_pn = 0;
      for (int p = 0; p < 5; p++) offer_pkt(1'b0, 1'b1);
      wait_claim("t2_first_claim");
      step();
      chk("t2_latency_before_write", {31'h0, data_avail_a}, 0);
      step();
      chk("t2_latency_after_write", {31'h0, data_avail_a}, 1);
      settle();
      chk("t2_claims", n_pn, 5);
      chk_ovf("t2_ovf", 1'b1);
      dn_ctl = 2;
      drain(900);

      // clear, then no claims while sync is low
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      exp_ovf8 = 0;
      exp_ovf2 = 0;
      step();
      chk_ovf("t3_clear", 1'b0);
      set_sync(1'b0);
      dn_ctl = 1;
      n_pn = 0;
      offer_pkt(1'b0, 1'b1);
      repeat (100) step();
      chk("t3_no_claim_sync_low", n_pn, 0);
      chk("t3_avail_sync_low", {31'h0, data_avail_a}, 0);
      chk_ovf("t3_no_drop", 1'b0);
      set_sync(1'b1);
      drain(300);
      chk("t3_claim_after_sync", n_pn, 1);

      // saturation: four stored, five dropped
      dn_ctl = 0;
      for (int p = 0; p < 9; p++) offer_pkt(1'b0, 1'b1);
      settle();
      chk_ovf("t4_sat", 1'b1);
      // clear coinciding with a drop entry
      offer_pkt(1'b0, 1'b1);
      exp_ovf8 = 1;
      exp_ovf2 = 1;
      wait_claim("t4_drop_claim");
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      settle();
      chk_ovf("t4_clr_with_drop", 1'b1);
      dn_ctl = 2;
      drain(900);

      // reset in the middle of a fetch
      dn_ctl = 0;
      offer_pkt(1'b0, 1'b0);
      wait_claim("t5_claim");
      repeat (5) step();
      rst = 1'b0;
      step();
      chk_all_zero("t5_midreset");
      rst = 1'b1;
      exp_ovf8 = 0;
      exp_ovf2 = 0;
      occ = 0;
      step();
      n_pn = 0;
      offer_pkt(1'b0, 1'b1);
      dn_ctl = 2;
      drain(400);
      chk("t5_refetch_claims", n_pn, 1);
      chk_ovf("t5_ovf_after_reset", 1'b0);

      // sync rise followed by one packet
      set_sync(1'b0);
      repeat (3) step();
      set_sync(1'b1);
      offer_pkt(1'b1, 1'b1);
      dn_ctl = 1;
      drain(300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
